i2c_target_rx: RTL and testbench



---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_target_rx.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg
//   Definitions shared by the I2C target receiver and the OLED master side:
//   the receiver state encoding, the ACK/NACK line levels and the OLED
//   controller's 7-bit bus address.
package i2c_pkg;

  // 7-bit address of the OLED controller; the write wire byte is 8'h78.
  localparam logic [6:0] OLED_ADDR = 7'h3C;

  // Level on sda during the ninth clock of a byte.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_CTRL     = 3'd3,
    ST_CTRL_ACK = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } i2c_state_e;

  // True when an address byte is a write to the given 7-bit address.
  function automatic logic is_write_match(input logic [7:0] addr_byte,
                                          input logic [6:0] addr);
    return (addr_byte[7:1] == addr) && (addr_byte[0] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
//   Brings one asynchronous I2C line into the clk domain and reports edges.
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     din        : raw bus line
//     level      : synchronised line level
//     rise, fall : one-clk pulses on a 0->1 / 1->0 change of level
//   All flops reset to 1 so an idle (pulled-up) bus produces no edges when
//   reset is released.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx
//   I2C target write-receiver. Oversamples sck/sda, detects START/STOP,
//   ACKs write frames addressed to TARGET_ADDR and captures the control
//   byte followed by any number of data bytes.
//   Ports:
//     clk, rst_n  : system clock (>= 8x sck), asynchronous active-low reset
//     sck         : I2C clock, never driven (held at z)
//     sda         : I2C data, open-drain; pulled to 0 only in ACK slots
//     ctrl_byte   : control byte of the current / last accepted frame
//     data_byte   : last captured data byte
//     ctrl_valid  : one-clk pulse when ctrl_byte updates
//     data_valid  : one-clk pulse when data_byte updates
//     frame_done  : one-clk pulse on the STOP that ends an addressed frame
//     busy        : high from address match until STOP or START
//   Handshake: the *_valid and frame_done strobes are single-cycle and have
//   no back-pressure; the paired byte output is stable from the strobe until
//   the next strobe of the same kind.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = OLED_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        sck,
  inout  wire        sda,
  output logic [7:0] ctrl_byte,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       ctrl_valid,
  output logic       frame_done,
  output logic       busy
);

  // Synchronised lines and their edges.
  logic s_scl, scl_rise, scl_fall;
  logic s_sda, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck),
    .level (s_scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda),
    .level (s_sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_evt, stop_evt;
  assign start_evt = sda_fall & s_scl;
  assign stop_evt  = sda_rise & s_scl;

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_on_q, ack_on_d;     // ACK slot entered: sda is being held low
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] ctrl_byte_q, ctrl_byte_d;
  logic [7:0] data_byte_q, data_byte_d;
  logic       ctrl_valid_q, ctrl_valid_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;

  // The byte including the bit sampled on this scl rise.
  logic [7:0] byte_full;
  assign byte_full = {shift_q[6:0], s_sda};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    ack_on_d     = ack_on_q;
    sda_oe_d     = sda_oe_q;
    ctrl_byte_d  = ctrl_byte_q;
    data_byte_d  = data_byte_q;
    ctrl_valid_d = 1'b0;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;

    if (start_evt) begin
      // Also covers repeated START; any partial byte is dropped.
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      ack_on_d = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_evt) begin
      state_d      = ST_IDLE;
      cnt_d        = 3'd0;
      ack_on_d     = 1'b0;
      sda_oe_d     = 1'b0;
      frame_done_d = busy_q;
      busy_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_CTRL, ST_DATA: begin
          if (scl_rise) begin
            shift_d = byte_full;
            if (cnt_q == 3'd7) begin
              cnt_d = 3'd0;
              if (state_q == ST_ADDR) begin
                if (is_write_match(byte_full, TARGET_ADDR)) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_CTRL) begin
                state_d      = ST_CTRL_ACK;
                ctrl_byte_d  = byte_full;
                ctrl_valid_d = 1'b1;
              end else begin
                state_d      = ST_DATA_ACK;
                data_byte_d  = byte_full;
                data_valid_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
          // First fall opens the ACK slot, second fall (after the 9th
          // clock) closes it and starts the next byte.
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
              sda_oe_d = 1'b1;
            end else begin
              ack_on_d = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = (state_q == ST_ADDR_ACK) ? ST_CTRL : ST_DATA;
            end
          end
        end
        default: begin
          // IDLE and IGNORE only leave on START/STOP.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 8'h00;
      ack_on_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      ctrl_byte_q  <= 8'h00;
      data_byte_q  <= 8'h00;
      ctrl_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ack_on_q     <= ack_on_d;
      sda_oe_q     <= sda_oe_d;
      ctrl_byte_q  <= ctrl_byte_d;
      data_byte_q  <= data_byte_d;
      ctrl_valid_q <= ctrl_valid_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // A STOP/START seen while driving lets go of sda in that same cycle
  // rather than one clock later.
  logic sda_low;
  assign sda_low = sda_oe_q & ~stop_evt & ~start_evt;

  assign sda = sda_low ? I2C_ACK : 1'bz;
  assign sck = 1'bz;

  assign ctrl_byte  = ctrl_byte_q;
  assign data_byte  = data_byte_q;
  assign ctrl_valid = ctrl_valid_q;
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx
//   Bench for i2c_target_rx: a bit-banged I2C master drives directed and
//   random write frames; a reference model derives the expected ACKs and
//   strobes, and a monitor pops expected strobes as the DUT produces them.
module tb_i2c_target_rx;
  import i2c_pkg::*;

  localparam logic [6:0] TARGET = 7'h3C;
  localparam int         Q      = 40;   // quarter sck period in ns

  localparam logic [1:0] T_CTRL = 2'd0;
  localparam logic [1:0] T_DATA = 2'd1;
  localparam logic [1:0] T_DONE = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda_low;
  wire        sck;
  wire        sda;
  logic [7:0] ctrl_byte, data_byte;
  logic       data_valid, ctrl_valid, frame_done, busy;

  assign sck = m_scl;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_rx #(.TARGET_ADDR(TARGET), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .sda        (sda),
    .ctrl_byte  (ctrl_byte),
    .data_byte  (data_byte),
    .data_valid (data_valid),
    .ctrl_valid (ctrl_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];        // {kind, byte}
  logic [7:0] tx_q[$];         // bytes following the address
  logic [7:0] exp_ctrl, exp_data;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic pop_cmp(input string name, input logic [9:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected strobe got=%0h expected=none at %0t",
               name, got, $time);
    end else begin
      check(name, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (ctrl_valid && data_valid)
      check("ctrl_data_overlap", 32'd1, 32'd0);
    if (ctrl_valid) pop_cmp("ctrl_strobe", {T_CTRL, ctrl_byte});
    if (data_valid) pop_cmp("data_strobe", {T_DATA, data_byte});
    if (frame_done) pop_cmp("frame_done", {T_DONE, 8'h00});
  end

  // ---------------- driver tasks ----------------
  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      m_sda_low = 1'b0; #Q;
      m_scl     = 1'b1; #Q;
    end
    m_sda_low = 1'b1; #Q;
    m_scl     = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    m_scl     = 1'b1; #Q;
    m_sda_low = 1'b0; #(2*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda_low = ~b[7-i]; #Q;
      m_scl     = 1'b1;    #(2*Q);
      m_scl     = 1'b0;    #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda_low = 1'b0; #Q;
    m_scl     = 1'b1; #Q;
    ack       = sda;  #Q;
    m_scl     = 1'b0; #Q;
  endtask

  // Reference model: a write to TARGET is ACKed byte by byte, the first
  // following byte is the control byte, the rest are data; anything else
  // is never ACKed and yields no strobes.
  task automatic frame(input logic [7:0] addr, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (addr == {TARGET, 1'b0});
    i2c_start();
    send_byte(addr, ack);
    check("addr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
    check("busy_after_addr", 32'(busy), 32'(hit));
    for (int k = 0; k < tx_q.size(); k++) begin
      if (hit) begin
        if (k == 0) begin
          exp_q.push_back({T_CTRL, tx_q[k]});
          exp_ctrl = tx_q[k];
        end else begin
          exp_q.push_back({T_DATA, tx_q[k]});
          exp_data = tx_q[k];
        end
      end
      send_byte(tx_q[k], ack);
      check("byte_ack", 32'(ack), hit ? 32'd0 : 32'd1);
    end
    if (do_stop) begin
      if (hit) exp_q.push_back({T_DONE, 8'h00});
      i2c_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      check("sda_idle_after_stop", 32'(sda), 32'd1);
    end
    check("ctrl_byte_level", 32'(ctrl_byte), 32'(exp_ctrl));
    check("data_byte_level", 32'(data_byte), 32'(exp_data));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda"},        32'(sda),        32'd1);
    check({tag, "_ctrl_byte"},  32'(ctrl_byte),  32'd0);
    check({tag, "_data_byte"},  32'(data_byte),  32'd0);
    check({tag, "_ctrl_valid"}, 32'(ctrl_valid), 32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ack;
    rst_n     = 1'b0;
    m_scl     = 1'b1;
    m_sda_low = 1'b0;
    exp_ctrl  = 8'h00;
    exp_data  = 8'h00;
    #52;
    check_reset_outputs("reset");
    check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;
    #100;

    // Basic write frame.
    tx_q = '{8'h00, 8'hAF};
    frame(8'h78, 1'b1);

    // Wrong address: nothing ACKed, no strobes.
    tx_q = '{8'h00, 8'h55};
    frame(8'h7A, 1'b1);

    // Read request is NACKed and ignored.
    tx_q = {};
    i2c_start();
    send_byte(8'h79, ack);
    check("read_nack", 32'(ack), 32'd1);
    check("read_state_ignore", 32'(dut.state_q), 32'(ST_IGNORE));
    i2c_stop();

    // Stream of data bytes.
    tx_q = '{8'h40, 8'h11, 8'h22, 8'h33};
    frame(8'h78, 1'b1);

    // Repeated START in the middle of a data byte.
    tx_q = '{8'h00};
    frame(8'h78, 1'b0);
    send_bits(8'hF0, 4);
    tx_q = '{8'h80, 8'h5A};
    frame(8'h78, 1'b1);

    // Reset while the CTRL byte is being ACKed.
    i2c_start();
    send_byte(8'h78, ack);
    check("rst_test_addr_ack", 32'(ack), 32'd0);
    exp_q.push_back({T_CTRL, 8'h3C});
    m_sda_low = 1'b0;
    send_bits(8'h3C, 8);
    m_sda_low = 1'b0;
    check("ctrl_ack_driven", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_ack_reset");
    exp_ctrl = 8'h00;
    exp_data = 8'h00;
    m_scl = 1'b1;
    #Q;
    rst_n = 1'b1;
    #(2*Q);
    tx_q = '{8'h00, 8'hAF};
    frame(8'h78, 1'b1);

    // Random frames.
    for (int f = 0; f < 16; f++) begin
      logic [7:0] addr;
      int         n;
      case ($urandom_range(0, 3))
        0:       addr = 8'h78;
        1:       addr = 8'h79;
        2:       addr = 8'h7A;
        default: addr = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) addr = 8'h78;
      n = $urandom_range(1, 4);
      tx_q = {};
      for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
      frame(addr, 1'b1);
    end

    #200;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
